// File: rtl/udp_pkg.sv
// udp_pkg: UDP header type, protocol constants and FSM state encoding
// shared by the UDP checksum checker.
package udp_pkg;
  localparam logic [7:0] UDP_PROTO = 8'h11;
  localparam int UDP_HDR_BYTES = 8;
  typedef struct packed {
    logic [47:0] eth_dest_mac;
    logic [47:0] eth_src_mac;
    logic [15:0] eth_type;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_length;
    logic [15:0] udp_checksum;
  } udp_hdr_t;
  localparam int UDP_HDR_W = $bits(udp_hdr_t);
  typedef enum logic [2:0] {
    ST_IDLE, ST_PAYLOAD, ST_DROP, ST_FOLD, ST_CHECK, ST_HDR_OUT, ST_DRAIN
  } state_t;
  // pseudo-header plus UDP header words; udp_length counts once for each
  function automatic logic [19:0] csum_seed(udp_hdr_t h);
    return 20'(h.ip_src[31:16]) + 20'(h.ip_src[15:0]) + 20'(h.ip_dst[31:16]) +
           20'(h.ip_dst[15:0]) + 20'(UDP_PROTO) + 20'(h.udp_length) +
           20'(h.src_port) + 20'(h.dst_port) + 20'(h.udp_length) + 20'(h.udp_checksum);
  endfunction
endpackage

// File: rtl/udp_csum_fifo_64.sv
// udp_csum_fifo_64: single-clock FIFO whose write pointer becomes visible to
// the reader only on commit, and can be rewound to the last commit.
module udp_csum_fifo_64 #(
  parameter int DEPTH = 1024,
  parameter int W = 74
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_commit,
  input  logic         i_rewind,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_cm, r_rd;
  assign o_full = (r_wr - r_rd) == (AW+1)'(DEPTH);
  assign o_empty = r_rd == r_cm;
  assign o_rd_data = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr[AW-1:0]] <= i_wr_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_cm <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= i_rewind ? r_cm : r_wr + (AW+1)'(i_wr_en);
      if (i_commit) r_cm <= r_wr;
      if (i_rd_en) r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/udp_checksum_check_64.sv
// udp_checksum_check_64: store-and-forward RFC 768 checksum verifier for one UDP frame.
// Define UDP_CSUM_DROP_BAD_EN to discard bad frames instead of flagging them.
module udp_checksum_check_64 import udp_pkg::*; #(
  parameter int PAYLOAD_FIFO_DEPTH = 1024,
  parameter int FOLD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_udp_hdr_valid,
  output logic                 s_udp_hdr_ready,
  input  logic [UDP_HDR_W-1:0] s_udp_hdr,
  input  logic [63:0]          s_udp_payload_axis_tdata,
  input  logic [7:0]           s_udp_payload_axis_tkeep,
  input  logic                 s_udp_payload_axis_tvalid,
  output logic                 s_udp_payload_axis_tready,
  input  logic                 s_udp_payload_axis_tlast,
  input  logic                 s_udp_payload_axis_tuser,
  output logic                 m_udp_hdr_valid,
  input  logic                 m_udp_hdr_ready,
  output logic [UDP_HDR_W-1:0] m_udp_hdr,
  output logic                 m_udp_checksum_ok,
  output logic [63:0]          m_udp_payload_axis_tdata,
  output logic [7:0]           m_udp_payload_axis_tkeep,
  output logic                 m_udp_payload_axis_tvalid,
  input  logic                 m_udp_payload_axis_tready,
  output logic                 m_udp_payload_axis_tlast,
  output logic                 m_udp_payload_axis_tuser,
  output logic                 busy,
  output logic                 error_checksum,
  output logic                 error_overflow
);
  state_t r_state;
  udp_hdr_t r_hdr, w_in_hdr;
  logic [FOLD_W-1:0] r_sum, w_beat_sum, w_fold;
  logic [63:0] w_masked;
  logic [73:0] w_rd_data;
  logic r_ok, r_last_user, r_fold_n, r_run, r_hdr_valid, r_err_csum, r_err_ovf;
  logic w_full, w_empty, w_wr, w_rd, w_commit, w_rewind, w_ok;
  assign w_in_hdr = udp_hdr_t'(s_udp_hdr);
  assign s_udp_hdr_ready = r_run && r_state == ST_IDLE;
  assign s_udp_payload_axis_tready = (r_state == ST_PAYLOAD && !w_full) || r_state == ST_DROP;
  assign w_wr = r_state == ST_PAYLOAD && s_udp_payload_axis_tvalid && !w_full;
  assign w_fold = FOLD_W'(r_sum[15:0]) + FOLD_W'(r_sum[FOLD_W-1:16]);
  assign w_ok = (r_hdr.udp_checksum == 16'h0000 || r_sum[15:0] == 16'hFFFF) &&
                r_hdr.udp_length >= 16'(UDP_HDR_BYTES) && !r_last_user;
  always_comb begin
    w_masked = '0;
    w_beat_sum = '0;
    for (int i = 0; i < 8; i++)
      w_masked[8*i +: 8] = s_udp_payload_axis_tkeep[i] ? s_udp_payload_axis_tdata[8*i +: 8] : 8'h00;
    for (int i = 0; i < 4; i++)
      w_beat_sum = w_beat_sum + FOLD_W'({w_masked[16*i +: 8], w_masked[16*i+8 +: 8]});
  end
`ifdef UDP_CSUM_DROP_BAD_EN
  assign w_commit = r_state == ST_CHECK && w_ok;
  assign w_rewind = (r_state == ST_PAYLOAD && w_full) || (r_state == ST_CHECK && !w_ok);
  assign m_udp_checksum_ok = r_hdr_valid;
`else
  assign w_commit = r_state == ST_CHECK;
  assign w_rewind = r_state == ST_PAYLOAD && w_full;
  assign m_udp_checksum_ok = r_ok;
`endif
  assign w_rd = m_udp_payload_axis_tvalid && m_udp_payload_axis_tready;
  assign m_udp_payload_axis_tvalid = r_state == ST_DRAIN && !w_empty;
  assign m_udp_payload_axis_tdata = w_rd_data[73:10];
  assign m_udp_payload_axis_tkeep = w_rd_data[9:2];
  assign m_udp_payload_axis_tlast = w_rd_data[1];
  assign m_udp_payload_axis_tuser = w_rd_data[0] | (w_rd_data[1] & !r_ok);
  assign m_udp_hdr_valid = r_hdr_valid;
  assign m_udp_hdr = r_hdr;
  assign busy = r_state != ST_IDLE;
  assign error_checksum = r_err_csum;
  assign error_overflow = r_err_ovf;
  udp_csum_fifo_64 #(.DEPTH(PAYLOAD_FIFO_DEPTH), .W(74)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_wr_en(w_wr),
    .i_wr_data({s_udp_payload_axis_tdata, s_udp_payload_axis_tkeep,
                s_udp_payload_axis_tlast, s_udp_payload_axis_tuser}),
    .i_commit(w_commit),
    .i_rewind(w_rewind),
    .i_rd_en(w_rd),
    .o_rd_data(w_rd_data),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hdr <= '0;
      r_sum <= '0;
      r_ok <= 1'b0;
      r_last_user <= 1'b0;
      r_fold_n <= 1'b0;
      r_run <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_err_csum <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_err_csum <= 1'b0;
      r_err_ovf <= 1'b0;
      case (r_state)
        ST_IDLE: if (s_udp_hdr_valid && s_udp_hdr_ready) begin
          r_hdr <= w_in_hdr;
          r_sum <= FOLD_W'(csum_seed(w_in_hdr));
          r_last_user <= 1'b0;
          r_state <= ST_PAYLOAD;
        end
        // reaching full without tlast means the frame cannot fit
        ST_PAYLOAD: if (w_full) begin
          r_err_ovf <= 1'b1;
          r_state <= ST_DROP;
        end else if (w_wr) begin
          r_sum <= r_sum + w_beat_sum;
          if (s_udp_payload_axis_tlast) begin
            r_last_user <= s_udp_payload_axis_tuser;
            r_fold_n <= 1'b0;
            r_state <= ST_FOLD;
          end
        end
        ST_DROP: if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast) r_state <= ST_IDLE;
        ST_FOLD: begin
          r_sum <= w_fold;
          r_fold_n <= 1'b1;
          if (r_fold_n && w_fold[FOLD_W-1:16] == '0) r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          r_ok <= w_ok;
          r_err_csum <= !w_ok;
`ifdef UDP_CSUM_DROP_BAD_EN
          r_hdr_valid <= w_ok;
          r_state <= w_ok ? ST_HDR_OUT : ST_IDLE;
`else
          r_hdr_valid <= 1'b1;
          r_state <= ST_HDR_OUT;
`endif
        end
        ST_HDR_OUT: if (m_udp_hdr_ready) begin
          r_hdr_valid <= 1'b0;
          r_state <= ST_DRAIN;
        end
        ST_DRAIN: if (w_rd && w_rd_data[1]) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_checksum_check_64.sv
// tb_udp_checksum_check_64: randomized scoreboard bench with a byte-level
// RFC 768 reference model for udp_checksum_check_64.
module tb_udp_checksum_check_64;
  import udp_pkg::*;
  localparam int DEPTH = 16;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic s_udp_hdr_valid = 1'b0, s_udp_hdr_ready;
  logic [UDP_HDR_W-1:0] s_udp_hdr = '0;
  logic [63:0] s_tdata = '0;
  logic [7:0] s_tkeep = '0;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
  logic m_udp_hdr_valid, m_udp_hdr_ready = 1'b0, m_udp_checksum_ok;
  logic [UDP_HDR_W-1:0] m_udp_hdr;
  logic [63:0] m_tdata;
  logic [7:0] m_tkeep;
  logic m_tvalid, m_tready = 1'b0, m_tlast, m_tuser;
  logic busy, error_checksum, error_overflow;
  int total = 0, bad = 0, cyc = 0, tlast_cyc = 0;
  int exp_csum_err = 0, exp_ovf = 0, got_csum_err = 0, got_ovf = 0;
  logic toggle_mode = 1'b0, prev_valid = 1'b0;
  udp_hdr_t exp_hdr_q[$];
  logic exp_ok_q[$];
  beat_t exp_beat_q[$];
  udp_hdr_t f_hdr;
  beat_t f_beats[$];

  udp_checksum_check_64 #(.PAYLOAD_FIFO_DEPTH(DEPTH), .FOLD_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready), .s_udp_hdr(s_udp_hdr),
    .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tkeep(s_tkeep),
    .s_udp_payload_axis_tvalid(s_tvalid), .s_udp_payload_axis_tready(s_tready),
    .s_udp_payload_axis_tlast(s_tlast), .s_udp_payload_axis_tuser(s_tuser),
    .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready), .m_udp_hdr(m_udp_hdr),
    .m_udp_checksum_ok(m_udp_checksum_ok),
    .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tkeep(m_tkeep),
    .m_udp_payload_axis_tvalid(m_tvalid), .m_udp_payload_axis_tready(m_tready),
    .m_udp_payload_axis_tlast(m_tlast), .m_udp_payload_axis_tuser(m_tuser),
    .busy(busy), .error_checksum(error_checksum), .error_overflow(error_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    m_udp_hdr_ready = 1'($urandom_range(0, 1));
    m_tready = toggle_mode ? cyc[0] : ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want handshake", name);
  endtask

  // one's-complement sum over pseudo-header, UDP header and kept payload bytes
  function automatic logic [15:0] model_sum();
    logic [7:0] q[$];
    logic [159:0] ph;
    int s = 0;
    ph = {f_hdr.ip_src, f_hdr.ip_dst, 8'h00, 8'h11, f_hdr.udp_length, f_hdr.src_port,
          f_hdr.dst_port, f_hdr.udp_length, f_hdr.udp_checksum};
    for (int i = 19; i >= 0; i--) q.push_back(ph[8*i +: 8]);
    foreach (f_beats[b])
      for (int j = 0; j < 8; j++)
        if (f_beats[b].k[j]) q.push_back(f_beats[b].d[8*j +: 8]);
    for (int i = 0; i < q.size(); i += 2)
      s += {q[i], (i + 1 < q.size()) ? q[i+1] : 8'h00};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return 16'(s);
  endfunction

  function automatic logic model_ok();
    return (f_hdr.udp_checksum == 16'h0000 || model_sum() == 16'hFFFF) &&
           f_hdr.udp_length >= 16'd8 && !f_beats[f_beats.size()-1].u;
  endfunction

  task automatic build_frame(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] sp,
                             input logic [15:0] dp, input int nbytes, input logic user,
                             input logic compute, input logic [15:0] csum);
    int nb, n;
    beat_t b;
    f_hdr.eth_dest_mac = 48'({$urandom(), $urandom()});
    f_hdr.eth_src_mac = 48'({$urandom(), $urandom()});
    f_hdr.eth_type = 16'h0800;
    f_hdr.ip_src = src;
    f_hdr.ip_dst = dst;
    f_hdr.src_port = sp;
    f_hdr.dst_port = dp;
    f_hdr.udp_length = 16'(8 + nbytes);
    f_beats.delete();
    nb = (nbytes == 0) ? 1 : (nbytes + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      n = nbytes - 8 * i;
      if (n > 8) n = 8;
      if (n < 0) n = 0;
      b.k = 8'((9'h1 << n) - 9'h1);
      b.d = {$urandom(), $urandom()};
      for (int j = 0; j < 8; j++) if (!b.k[j]) b.d[8*j +: 8] = 8'h00;
      b.l = (i == nb - 1);
      b.u = b.l & user;
      f_beats.push_back(b);
    end
    f_hdr.udp_checksum = 16'h0000;
    f_hdr.udp_checksum = compute ? ~model_sum() : csum;
  endtask

  task automatic drive_hdr();
    int n = 0;
    @(posedge clk);
    #1;
    s_udp_hdr_valid = 1'b1;
    s_udp_hdr = f_hdr;
    @(negedge clk);
    while (!s_udp_hdr_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (!s_udp_hdr_ready) fail("hdr_timeout");
    else begin
      check("hdr_after_drain", exp_beat_q.size(), 0);
      check("busy_idle", busy, 0);
    end
    @(posedge clk);
    #1;
    s_udp_hdr_valid = 1'b0;
  endtask

  task automatic drive_beat(input beat_t b);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata = b.d;
    s_tkeep = b.k;
    s_tlast = b.l;
    s_tuser = b.u;
    @(negedge clk);
    while (!s_tready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) fail("beat_timeout");
    if (b.l) tlast_cyc = cyc + 1;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send(input int force_ok);
    logic ok, drop;
    beat_t e;
    drop = f_beats.size() > DEPTH;
    ok = (force_ok < 0) ? model_ok() : (force_ok != 0);
    drive_hdr();
    if (drop) exp_ovf++;
    else begin
      if (!ok) exp_csum_err++;
`ifdef UDP_CSUM_DROP_BAD_EN
      if (ok) begin
`else
      begin
`endif
        exp_hdr_q.push_back(f_hdr);
        exp_ok_q.push_back(ok);
        foreach (f_beats[i]) begin
          e = f_beats[i];
          e.u = e.u | (e.l & !ok);
          exp_beat_q.push_back(e);
        end
      end
    end
    foreach (f_beats[i]) drive_beat(f_beats[i]);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_hdr_q.size() != 0 || exp_beat_q.size() != 0) && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (exp_hdr_q.size() != 0 || exp_beat_q.size() != 0) fail("drain_timeout");
    repeat (6) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_udp_hdr_valid && !prev_valid) check("hdr_latency", cyc - tlast_cyc, 3);
      prev_valid = m_udp_hdr_valid;
      if (m_udp_hdr_valid && m_udp_hdr_ready) begin
        if (exp_hdr_q.size() == 0) check("unexpected_hdr", m_udp_hdr_valid, 0);
        else begin
          check("hdr", m_udp_hdr, exp_hdr_q.pop_front());
          check("checksum_ok", m_udp_checksum_ok, exp_ok_q.pop_front());
        end
      end
      if (m_tvalid && m_tready) begin
        if (exp_beat_q.size() == 0) check("unexpected_beat", m_tvalid, 0);
        else check("beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, exp_beat_q.pop_front());
      end
      if (error_checksum) got_csum_err++;
      if (error_overflow) got_ovf++;
    end else prev_valid = 1'b0;
  end

  initial begin
    beat_t b;
    #23;
    check("reset_outputs", {s_udp_hdr_ready, s_tready, m_udp_hdr_valid, m_udp_checksum_ok,
                            m_tvalid, busy, error_checksum, error_overflow}, 0);
    check("reset_hdr", m_udp_hdr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_ready", {s_udp_hdr_ready, busy}, 2'b10);
    // known-good frame, then one-off checksum, then checksum disabled
    build_frame(32'hC0A80101, 32'hC0A80102, 16'h1234, 16'h5678, 4, 1'b0, 1'b0, 16'h7638);
    b = f_beats[0]; b.d = 64'hEFBEADDE; f_beats[0] = b;
    send(1);
    build_frame(32'hC0A80101, 32'hC0A80102, 16'h1234, 16'h5678, 4, 1'b0, 1'b0, 16'h7639);
    b = f_beats[0]; b.d = 64'hEFBEADDE; f_beats[0] = b;
    send(0);
    build_frame(32'hC0A80101, 32'hC0A80102, 16'h1234, 16'h5678, 4, 1'b0, 1'b0, 16'h0000);
    b = f_beats[0]; b.d = 64'hEFBEAD00; f_beats[0] = b;
    send(1);
    build_frame($urandom(), $urandom(), 16'h0001, 16'h0002, 4, 1'b0, 1'b0, 16'h0000);
    f_hdr.udp_length = 16'd4;
    send(0);
    build_frame($urandom(), $urandom(), 16'h0003, 16'h0004, 13, 1'b1, 1'b1, 16'h0000);
    send(0);
    build_frame($urandom(), $urandom(), 16'h0005, 16'h0006, 8 * (DEPTH + 3), 1'b0, 1'b1, 16'h0000);
    send(-1);
    build_frame($urandom(), $urandom(), 16'h0007, 16'h0008, 20, 1'b0, 1'b1, 16'h0000);
    send(1);
    build_frame($urandom(), $urandom(), 16'h0009, 16'h000A, 8 * DEPTH, 1'b0, 1'b1, 16'h0000);
    send(1);
    build_frame($urandom(), $urandom(), 16'h000B, 16'h000C, 0, 1'b0, 1'b1, 16'h0000);
    send(1);
    wait_drain();
    toggle_mode = 1'b1;
    build_frame($urandom(), $urandom(), 16'h0010, 16'h0011, 37, 1'b0, 1'b1, 16'h0000);
    send(-1);
    build_frame($urandom(), $urandom(), 16'h0012, 16'h0013, 50, 1'b0, 1'b1, 16'h0000);
    send(-1);
    wait_drain();
    toggle_mode = 1'b0;
    // reset in the middle of a payload
    build_frame($urandom(), $urandom(), 16'h0020, 16'h0021, 30, 1'b0, 1'b1, 16'h0000);
    drive_hdr();
    drive_beat(f_beats[0]);
    drive_beat(f_beats[1]);
    s_tvalid = 1'b1;
    s_tdata = f_beats[2].d;
    s_tkeep = f_beats[2].k;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {s_udp_hdr_ready, s_tready, m_udp_hdr_valid, m_udp_checksum_ok,
                               m_tvalid, busy, error_checksum, error_overflow}, 0);
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_idle", {s_udp_hdr_ready, busy}, 2'b10);
    build_frame($urandom(), $urandom(), 16'h0022, 16'h0023, 25, 1'b0, 1'b1, 16'h0000);
    send(1);
    for (int t = 0; t < 25; t++) begin
      build_frame($urandom(), $urandom(), 16'($urandom()), 16'($urandom()),
                  $urandom_range(0, 8 * DEPTH + 12), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, 16'($urandom()));
      send(-1);
    end
    wait_drain();
    check("csum_err_count", got_csum_err, exp_csum_err);
    check("overflow_count", got_ovf, exp_ovf);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
